// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard control with load-use/mul-div stalls, branch flush and a multi-cycle mul/div sequencer
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        idUsesRt,
    input  logic        idMulDiv,
    input  logic        idDiv,
    input  logic        idHiLoRead,
    input  logic        exMemRead,
    input  logic [4:0]  exDstReg,
    input  logic        exBranchTaken,
    output logic        oPCWrite,
    output logic        oIFIDWrite,
    output logic        oIFIDFlush,
    output logic        oIDEXFlush,
    output logic        oMDStart,
    output logic        oMDBusy,
    output logic        oMDDone,
    output logic [15:0] oStallCnt
);
    typedef enum logic {IDLE, MD_BUSY} state_t;
    state_t      state_q, state_d;
    logic [4:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        busy, load_use, md_haz, stall;
    always_comb begin
        busy        = state_q == MD_BUSY;
        load_use    = exMemRead && exDstReg != 5'd0 &&
                      (exDstReg == idRs || (idUsesRt && exDstReg == idRt));
        md_haz      = busy && (idHiLoRead || idMulDiv);
        stall       = (load_use || md_haz) && !exBranchTaken;
        oMDStart    = !rst && !busy && idMulDiv && !load_use && !exBranchTaken;
        oMDBusy     = busy;
        oMDDone     = busy && md_cnt_q == 5'd0;
        oPCWrite    = !rst && !stall;
        oIFIDWrite  = !rst && !stall;
        oIFIDFlush  = rst || exBranchTaken;
        oIDEXFlush  = rst || exBranchTaken || stall;
        oStallCnt   = stall_cnt_q;
        state_d     = oMDStart ? MD_BUSY : oMDDone ? IDLE : state_q;
        md_cnt_d    = oMDStart ? (idDiv ? 5'd31 : 5'd3) :
                      oMDDone  ? 5'd0 :
                      busy     ? md_cnt_q - 5'd1 : md_cnt_q;
        stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            md_cnt_q    <= 5'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  idRs, idRt, exDstReg;
    logic        idUsesRt, idMulDiv, idDiv, idHiLoRead, exMemRead, exBranchTaken;
    logic        oPCWrite, oIFIDWrite, oIFIDFlush, oIDEXFlush;
    logic        oMDStart, oMDBusy, oMDDone;
    logic [15:0] oStallCnt;
    int          vectors = 0;
    int          miscompares = 0;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRt(idUsesRt),
        .idMulDiv(idMulDiv), .idDiv(idDiv), .idHiLoRead(idHiLoRead),
        .exMemRead(exMemRead), .exDstReg(exDstReg), .exBranchTaken(exBranchTaken),
        .oPCWrite(oPCWrite), .oIFIDWrite(oIFIDWrite), .oIFIDFlush(oIFIDFlush),
        .oIDEXFlush(oIDEXFlush), .oMDStart(oMDStart), .oMDBusy(oMDBusy),
        .oMDDone(oMDDone), .oStallCnt(oStallCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ctl = {oPCWrite, oIFIDWrite, oIFIDFlush, oIDEXFlush}; md = {oMDStart, oMDBusy, oMDDone}
    task automatic chk_all(input string tag, input logic [3:0] ctl, input logic [2:0] md, input logic [15:0] cnt);
        chk({tag, "_ctl"}, {12'd0, oPCWrite, oIFIDWrite, oIFIDFlush, oIDEXFlush}, {12'd0, ctl});
        chk({tag, "_md"}, {13'd0, oMDStart, oMDBusy, oMDDone}, {13'd0, md});
        chk({tag, "_cnt"}, oStallCnt, cnt);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clr;
        idRs = 0; idRt = 0; exDstReg = 0; idUsesRt = 0; idMulDiv = 0; idDiv = 0;
        idHiLoRead = 0; exMemRead = 0; exBranchTaken = 0;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        idMulDiv = 1;
        #1 chk_all("reset", 4'b0011, 3'b000, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        clr();
        tick();
        #1 chk_all("idle", 4'b1100, 3'b000, 16'd0);
        exMemRead = 1; exDstReg = 0; idRs = 0; idUsesRt = 1;
        #1 chk_all("zero_reg", 4'b1100, 3'b000, 16'd0);
        tick();
        #1 chk("zero_reg_cnt", oStallCnt, 16'd0);
        exDstReg = 8; idRs = 8; idUsesRt = 0;
        #1 chk_all("load_use", 4'b0001, 3'b000, 16'd0);
        tick();
        #1 chk("load_use_cnt", oStallCnt, 16'd1);
        exDstReg = 9; idRs = 1; idRt = 9; idUsesRt = 0;
        #1 chk_all("rt_unused", 4'b1100, 3'b000, 16'd1);
        idUsesRt = 1;
        #1 chk_all("rt_used", 4'b0001, 3'b000, 16'd1);
        tick();
        #1 chk("rt_used_cnt", oStallCnt, 16'd2);
        clr();
        exMemRead = 1; exDstReg = 8; idRs = 8; exBranchTaken = 1; idMulDiv = 1;
        #1 chk_all("branch_over_stall", 4'b1111, 3'b000, 16'd2);
        tick();
        #1 chk_all("branch_after", 4'b1111, 3'b000, 16'd2);
        clr();
        idMulDiv = 1;
        #1 chk_all("mult_start", 4'b1100, 3'b100, 16'd2);
        tick();
        clr();
        idHiLoRead = 1;
        // mfhi waits through 4 busy cycles; a branch in cycle 1 overrides that stall
        for (int k = 0; k < 4; k++) begin
            exBranchTaken = (k == 1);
            #1 chk({"mult_ctl", 8'(48 + k)}, {12'd0, oPCWrite, oIFIDWrite, oIFIDFlush, oIDEXFlush},
                   (k == 1) ? 16'hF : 16'h1);
            chk({"mult_md", 8'(48 + k)}, {13'd0, oMDStart, oMDBusy, oMDDone}, {14'd1, k == 3});
            tick();
        end
        exBranchTaken = 0;
        #1 chk_all("mfhi_go", 4'b1100, 3'b000, 16'd5);
        clr();
        idMulDiv = 1; idDiv = 1;
        #1 chk_all("div_start", 4'b1100, 3'b100, 16'd5);
        tick();
        idDiv = 0;
        // a queued mul/div stalls through all 32 busy cycles, including the done cycle
        for (int k = 0; k < 32; k++) begin
            #1 chk("div_ctl", {12'd0, oPCWrite, oIFIDWrite, oIFIDFlush, oIDEXFlush}, 16'h1);
            chk("div_md", {13'd0, oMDStart, oMDBusy, oMDDone}, {14'd1, k == 31});
            tick();
        end
        idDiv = 1;
        #1 chk_all("div2_start", 4'b1100, 3'b100, 16'd37);
        tick();
        clr();
        for (int k = 1; k < 10; k++) begin
            #1 chk("div2_busy", {13'd0, oMDStart, oMDBusy, oMDDone}, 16'b010);
            tick();
        end
        #1 chk("div2_busy10", {13'd0, oMDStart, oMDBusy, oMDDone}, 16'b010);
        idMulDiv = 1;
        rst = 1'b1;
        #1 chk_all("rst_mid_div", 4'b0011, 3'b000, 16'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1 chk_all("rst_hold", 4'b0011, 3'b000, 16'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        idMulDiv = 0;
        tick();
        #1 chk_all("post_rst", 4'b1100, 3'b000, 16'd0);
        for (int k = 0; k < 24; k++) begin
            tick();
            #1 chk("post_rst_no_done", {13'd0, oMDStart, oMDBusy, oMDDone}, 16'b000);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port idRs, idRt  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have port idUsesRt  in  1  ID instruction reads idRt.
REQ-005 SHALL have port idMulDiv, idDiv  in  1 each  ID instruction is mult/div; idDiv=1 selects divide.
REQ-006 SHALL have port idHiLoRead  in  1  ID instruction reads HI/LO (mfhi/mflo).
REQ-007 SHALL have port exMemRead  in  1  EX-stage instruction is a load.
REQ-008 SHALL have port exDstReg  in  5  EX-stage destination register.
REQ-009 SHALL have port exBranchTaken  in  1  branch resolved taken in EX this cycle.
REQ-010 SHALL have outputs oPCWrite, oIFIDWrite, oIFIDFlush, oIDEXFlush  out  1 each  PC/IF-ID enables and flushes; oIDEXFlush zeroes all ID/EX control fields (bubble).
REQ-011 SHALL have outputs oMDStart, oMDBusy, oMDDone  out  1 each  mul/div unit start pulse, busy level, completion pulse.
REQ-012 SHALL have output oStallCnt  out  16  stall-cycle performance counter.

Function
REQ-013 SHALL hold FSM states IDLE and MD_BUSY plus a 5-bit down-counter mdCnt.
REQ-014 SHALL detect loadUse = exMemRead & exDstReg!=0 & (exDstReg==idRs | (idUsesRt & exDstReg==idRt)).
REQ-015 SHALL detect mdHaz = (state==MD_BUSY) & (idHiLoRead | idMulDiv).
REQ-016 SHALL set stall = (loadUse | mdHaz) & !exBranchTaken.
REQ-017 SHALL on stall drive oPCWrite=0, oIFIDWrite=0, oIDEXFlush=1, oIFIDFlush=0.
REQ-018 SHALL on exBranchTaken drive oPCWrite=1, oIFIDWrite=1, oIFIDFlush=1, oIDEXFlush=1; branch flush overrides every stall.
REQ-019 SHALL otherwise drive oPCWrite=1, oIFIDWrite=1, both flushes 0.
REQ-020 SHALL assert oMDStart combinationally when state==IDLE & idMulDiv & !loadUse & !exBranchTaken.
REQ-021 SHALL on oMDStart transition IDLE->MD_BUSY at next edge, loading mdCnt=3 (mult) or 31 (div).
REQ-022 SHALL in MD_BUSY hold oMDBusy=1 and decrement mdCnt each cycle; when mdCnt==0 assert oMDDone for that cycle and return to IDLE at next edge (mult busy 4 cycles, div 32).
REQ-023 SHALL keep counting in MD_BUSY regardless of stalls or branch flushes.
REQ-024 SHALL treat mdCnt==0 cycle as still busy: mdHaz applies; a waiting HI/LO read or new mul/div proceeds the following cycle (new mul/div starts then).
REQ-025 SHALL increment oStallCnt by 1 on each cycle where stall=1, saturating at 16'hFFFF.
REQ-026 SHALL hold oMDBusy=0, oMDDone=0 in IDLE.

Reset
REQ-027 SHALL on rst assertion immediately force state=IDLE, mdCnt=0, oStallCnt=0, without waiting for clk.
REQ-028 SHALL while rst=1 drive oPCWrite=0, oIFIDWrite=0, oIFIDFlush=1, oIDEXFlush=1, oMDStart=0, oMDBusy=0, oMDDone=0.
REQ-029 SHALL on rst assertion mid-MD_BUSY abandon the operation with no oMDDone pulse.
REQ-030 SHALL resume normal evaluation on the first edge after rst deasserts, in IDLE.

Verification
REQ-031 SHALL cover load-use: exMemRead=1, exDstReg=8, idRs=8 -> one cycle oPCWrite=0, oIFIDWrite=0, oIDEXFlush=1, oStallCnt 0->1.
REQ-032 SHALL cover $zero: exMemRead=1, exDstReg=0, idRs=0 -> no stall, oStallCnt unchanged.
REQ-033 SHALL cover mult then mfhi: idMulDiv=1, idDiv=0 in IDLE -> oMDStart one cycle; oMDBusy 4 cycles; idHiLoRead held 1 during those -> 4 stall cycles, oMDDone on 4th, mfhi proceeds on 5th.
REQ-034 SHALL cover div: idMulDiv=1, idDiv=1 -> oMDBusy exactly 32 cycles, single oMDDone pulse.
REQ-035 SHALL cover branch over stall: loadUse=1 and exBranchTaken=1 same cycle -> oPCWrite=1, both flushes 1, oStallCnt unchanged, oMDStart=0 even if idMulDiv=1.
REQ-036 SHALL cover reset mid-div: rst pulsed at busy cycle 10 -> state IDLE, oMDBusy=0 immediately, no oMDDone, oStallCnt=0.
